// File: rtl/slot_alloc_pkg.sv
// Shared types and helpers for the parking-lot entry gate.
// Latency: pure combinational helpers, no state.
// Backpressure: none; constants and functions only.
package slot_alloc_pkg;

    localparam int SLOT_CNT = 15;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ALLOC     = 2'd1,
        OPEN      = 2'd2,
        WAIT_PARK = 2'd3
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Lowest index with a clear occupancy bit; 4'hF when every slot is taken
    function automatic logic [3:0] lowest_free(input logic [SLOT_CNT-1:0] occ);
        logic [3:0] idx;
        idx = 4'hF;
        for (int i = SLOT_CNT - 1; i >= 0; i--) begin
            if (!occ[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Values here never exceed 15, so one compare against 10 splits the digits
    function automatic logic [3:0] ones_digit(input logic [3:0] v);
        return (v >= 4'd10) ? v - 4'd10 : v;
    endfunction

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Entry-button synchroniser and debouncer producing a one-cycle press pulse.
// Latency: 2 sync cycles plus DEBOUNCE_CYCLES stable cycles to the pulse.
// Backpressure: none; pulses are fire-and-forget, the consumer may ignore them.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          btn_s1;
    logic          btn_sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Two-flop sync, then count how long the synced input disagrees with the accepted level
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1   <= 1'b0;
            btn_sync <= 1'b0;
            level    <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            btn_s1   <= btn;
            btn_sync <= btn_s1;
            press    <= 1'b0;
            if (btn_sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= btn_sync;
                press <= btn_sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/slot_allocator.sv
// Entry gate: allocates the lowest free slot, opens the gate, waits for the car, drives a 4-digit display.
// Latency: car edge to full 3 cycles; press pulse to slot_valid 2 cycles; gate open GATE_CYCLES cycles.
// Backpressure: presses arriving outside IDLE or while full are dropped, never queued.
module slot_allocator
    import slot_alloc_pkg::*;
#(
    parameter int N_SLOTS         = SLOT_CNT,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int GATE_CYCLES     = 300000000,
    parameter int PARK_TIMEOUT    = 1000000000,
    parameter int REFRESH_CYCLES  = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SLOTS-1:0] car,
    input  logic               entry_btn,
    output logic               gate_open,
    output logic               slot_valid,
    output logic [3:0]         slot_id,
    output logic               full,
    output logic [6:0]         seg,
    output logic [3:0]         an
);

    // One timer serves both OPEN and WAIT_PARK, so size it for the longer of the two
    localparam int TMR_MAX = (GATE_CYCLES > PARK_TIMEOUT) ? GATE_CYCLES : PARK_TIMEOUT;
    localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] PARK_LAST = TW'(PARK_TIMEOUT - 1);
    localparam int RW      = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

    logic [N_SLOTS-1:0] car_s1;
    logic [N_SLOTS-1:0] car_sync;
    logic [3:0]         free_cnt;
    logic               press;
    logic [3:0]         free_idx;
    logic               slot_parked;
    state_t             state;
    logic [TW-1:0]      timer;
    logic [RW-1:0]      refresh_cnt;
    logic [1:0]         digit;
    logic [6:0]         seg_nxt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (entry_btn),
        .press(press)
    );

    // Synchronise the sensors and register the free count and full flag together
    always_ff @(posedge clk) begin
        if (rst) begin
            car_s1   <= '0;
            car_sync <= '0;
            free_cnt <= '0;
            full     <= 1'b0;
        end else begin
            car_s1   <= car;
            car_sync <= car_s1;
            free_cnt <= 4'($countones(~car_sync));
            full     <= ($countones(car_sync) == N_SLOTS);
        end
    end

    assign free_idx = lowest_free(car_sync);

    // Pick out the sensor belonging to the currently allocated slot
    always_comb begin
        slot_parked = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (slot_id == 4'(i + 1)) slot_parked = car_sync[i];
        end
    end

    // Allocation FSM; slot_id is latched at ALLOC and held until the allocation ends
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            gate_open  <= 1'b0;
            slot_valid <= 1'b0;
            slot_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press && !full) state <= ALLOC;
                end
                ALLOC: begin
                    if (free_idx != 4'hF) begin
                        slot_id    <= free_idx + 4'd1;
                        slot_valid <= 1'b1;
                        gate_open  <= 1'b1;
                        timer      <= '0;
                        state      <= OPEN;
                    end else begin
                        state <= IDLE;
                    end
                end
                OPEN: begin
                    if (timer == GATE_LAST) begin
                        gate_open <= 1'b0;
                        timer     <= '0;
                        state     <= WAIT_PARK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_PARK: begin
                    if (slot_parked || (timer == PARK_LAST)) begin
                        slot_valid <= 1'b0;
                        slot_id    <= '0;
                        timer      <= '0;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Display scan position: hold each digit for REFRESH_CYCLES, wrap 3 -> 0
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit       <= '0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            digit       <= digit + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Segment pattern for the digit being scanned; tens digits can only ever be 1
    always_comb begin
        seg_nxt = SEG_BLANK;
        case (digit)
            2'd0: if (slot_valid) seg_nxt = seg_digit(ones_digit(slot_id));
            2'd1: if (slot_valid && (slot_id >= 4'd10)) seg_nxt = SEG_1;
            2'd2: seg_nxt = seg_digit(ones_digit(free_cnt));
            default: if (free_cnt >= 4'd10) seg_nxt = SEG_1;
        endcase
    end

    // seg and an share one register stage so they always switch on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= 4'b1111;
        end else begin
            seg <= seg_nxt;
            an  <= ~(4'b0001 << digit);
        end
    end

endmodule
